// File: rtl/alu_mc_pkg.sv
// Shared definitions for the handshaked ALU: opcodes, flag bit positions, FSM states.
package alu_mc_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLL = 4'd4;
  localparam logic [3:0] ALU_SRL = 4'd5;
  localparam logic [3:0] ALU_SRA = 4'd6;
  localparam logic [3:0] ALU_RL  = 4'd7;
  localparam logic [3:0] ALU_MUL = 4'd8;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mc_if.sv
// Operand/result handshake bundle for alu_mc; slave is the ALU, master the issuing stage.
interface alu_mc_if #(
  parameter int DSIZE = 16,
  parameter int SHW   = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [DSIZE-1:0] data1;
  logic [DSIZE-1:0] data2;
  logic [SHW-1:0]   imm;
  logic             out_valid;
  logic             out_ready;
  logic [DSIZE-1:0] result;
  logic [2:0]       flag;
  logic             busy;

  modport master (
    output in_valid, op, data1, data2, imm, out_ready,
    input  in_ready, out_valid, result, flag, busy
  );

  modport slave (
    input  in_valid, op, data1, data2, imm, out_ready,
    output in_ready, out_valid, result, flag, busy
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier, one multiplier bit per cycle over DSIZE cycles.
// done is asserted combinationally during the last step; product is valid alongside it.
module alu_mul_seq #(
  parameter int DSIZE = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DSIZE-1:0]   a,
  input  logic [DSIZE-1:0]   b,
  output logic               done,
  output logic [2*DSIZE-1:0] product
);
  localparam int CW = $clog2(DSIZE + 1);

  logic [2*DSIZE-1:0] mcand, acc, acc_nxt;
  logic [DSIZE-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               run;

  assign acc_nxt = acc + (mplier[0] ? mcand : '0);
  assign done    = run && (cnt == CW'(1));
  assign product = acc_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      run    <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      run    <= 1'b1;
      cnt    <= CW'(DSIZE);
      acc    <= '0;
      mcand  <= {{DSIZE{1'b0}}, a};
      mplier <= b;
    end else if (run) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
      if (cnt == CW'(1)) run <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_mc.sv
// Handshaked ALU with registered result/flags {Z,V,N}.
// Define ALU_MUL_EN to add op 8 (unsigned multiply) via the sequential multiplier.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int DSIZE = 16,
  parameter int SHW   = 4
) (
  input logic     clk,
  input logic     rst,
  alu_mc_if.slave bus
);
  localparam int MSB = DSIZE - 1;

  state_e             state, state_nxt;
  logic               accept, is_mul, mul_done;
  logic [DSIZE-1:0]   res_q, alu_res;
  logic [2:0]         flag_q, alu_flag;
  logic [DSIZE-1:0]   a, b, sum, diff;
  logic [SHW-1:0]     amt;
  logic [2*DSIZE-1:0] rot;
  logic               ovf;

  assign bus.in_ready  = (state == ST_IDLE) || (state == ST_DONE && bus.out_ready);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.result    = res_q;
  assign bus.flag      = flag_q;
  assign accept        = bus.in_valid && bus.in_ready;

`ifdef ALU_MUL_EN
  logic [2*DSIZE-1:0] prod;

  assign is_mul   = (bus.op == ALU_MUL);
  assign bus.busy = (state == ST_EXEC);

  alu_mul_seq #(.DSIZE(DSIZE)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && is_mul),
    .a       (bus.data1),
    .b       (bus.data2),
    .done    (mul_done),
    .product (prod)
  );
`else
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
  assign bus.busy = 1'b0;
`endif

  // Single-cycle datapath; flags default to their held value so untouched bits carry over.
  always_comb begin
    a        = bus.data1;
    b        = bus.data2;
    amt      = bus.imm;
    sum      = a + b;
    diff     = a - b;
    rot      = {a, a} << amt;
    ovf      = 1'b0;
    alu_res  = '0;
    alu_flag = flag_q;
    case (bus.op)
      ALU_ADD: begin
        alu_res          = sum;
        ovf              = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
        alu_flag[FLAG_Z] = (sum == '0);
        alu_flag[FLAG_V] = ovf;
        alu_flag[FLAG_N] = sum[MSB] & ~ovf;
      end
      ALU_SUB: begin
        alu_res          = diff;
        ovf              = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
        alu_flag[FLAG_Z] = (diff == '0);
        alu_flag[FLAG_V] = ovf;
        alu_flag[FLAG_N] = diff[MSB] & ~ovf;
      end
      ALU_AND: begin
        alu_res          = a & b;
        alu_flag[FLAG_Z] = ((a & b) == '0);
        alu_flag[FLAG_V] = 1'b0;
      end
      ALU_OR: begin
        alu_res          = a | b;
        alu_flag[FLAG_Z] = ((a | b) == '0);
        alu_flag[FLAG_V] = 1'b0;
      end
      ALU_SLL: alu_res = a << amt;
      ALU_SRL: alu_res = a >> amt;
      ALU_SRA: alu_res = $signed(a) >>> amt;
      ALU_RL:  alu_res = rot[2*DSIZE-1:DSIZE];
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (accept)                                state_nxt = is_mul ? ST_EXEC : ST_DONE;
        else if (state == ST_DONE && bus.out_ready) state_nxt = ST_IDLE;
      end
      ST_EXEC: if (mul_done) state_nxt = ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      res_q  <= '0;
      flag_q <= 3'b000;
    end else begin
      state <= state_nxt;
      if (accept && !is_mul) begin
        res_q  <= alu_res;
        flag_q <= alu_flag;
      end
`ifdef ALU_MUL_EN
      if (state == ST_EXEC && mul_done) begin
        res_q          <= prod[DSIZE-1:0];
        flag_q[FLAG_Z] <= (prod[DSIZE-1:0] == '0);
        flag_q[FLAG_V] <= |prod[2*DSIZE-1:DSIZE];
      end
`endif
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// Directed + random bench for alu_mc against an arithmetic reference model.
module tb_alu_mc;
  localparam int DW = 16;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_mc_if #(.DSIZE(DW), .SHW(SW)) bus ();
  alu_mc #(.DSIZE(DW), .SHW(SW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_res;
  logic [2:0]  exp_flag;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: computes result/flags from signed/unsigned integer arithmetic.
  task automatic model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] imm, output int lat);
    int sa, sb, s, t, u;
    longint p;
    logic v;
    sa = $signed(a);
    sb = $signed(b);
    u  = int'(a);
    lat = 1;
    case (op)
      4'd0, 4'd1: begin
        s = (op == 4'd0) ? sa + sb : sa - sb;
        v = (s > 32767) || (s < -32768);
        exp_res  = s[15:0];
        exp_flag = {exp_res == 16'h0, v, exp_res[15] & ~v};
      end
      4'd2: begin exp_res = a & b; exp_flag = {exp_res == 16'h0, 1'b0, exp_flag[0]}; end
      4'd3: begin exp_res = a | b; exp_flag = {exp_res == 16'h0, 1'b0, exp_flag[0]}; end
      4'd4: begin t = u * (1 << imm); exp_res = t[15:0]; end
      4'd5: begin t = u / (1 << imm); exp_res = t[15:0]; end
      4'd6: begin t = sa >>> imm;      exp_res = t[15:0]; end
      4'd7: begin t = (u * (1 << imm)) | (u >> (16 - imm)); exp_res = t[15:0]; end
`ifdef ALU_MUL_EN
      4'd8: begin
        p = longint'(u) * longint'(int'(b));
        exp_res  = p[15:0];
        exp_flag = {exp_res == 16'h0, p[31:16] != 16'h0, exp_flag[0]};
        lat = 17;
      end
`endif
      default: exp_res = 16'h0;
    endcase
  endtask

  // Issue one op, scramble inputs after accept, check latency/busy/result, optionally stall.
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] imm, input int hold);
    int lat_exp, lat, nbusy;
    @(negedge clk);
    bus.op = op; bus.data1 = a; bus.data2 = b; bus.imm = imm;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    #1 chk("in_ready_at_issue", bus.in_ready, 1);
    model(op, a, b, imm, lat_exp);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.data1 = 16'($urandom); bus.data2 = 16'($urandom);
    bus.imm = 4'($urandom); bus.op = 4'($urandom);
    bus.out_ready = (hold == 0);
    lat = 1; nbusy = 0;
    while (!bus.out_valid && lat < 40) begin
      nbusy += int'(bus.busy);
      @(posedge clk); #1;
      lat++;
    end
    chk("out_valid", bus.out_valid, 1);
    chk("latency", lat, lat_exp);
    chk("busy_cycles", nbusy, lat_exp - 1);
    chk("result", bus.result, exp_res);
    chk("flag", bus.flag, exp_flag);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_result", bus.result, exp_res);
      chk("hold_in_ready", bus.in_ready, 0);
    end
    if (hold > 0) begin
      bus.out_ready = 1'b1;
      #1 chk("in_ready_on_consume", bus.in_ready, 1);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = 4'd0;
    bus.data1 = 16'h0; bus.data2 = 16'h0; bus.imm = 4'd0;
    exp_flag = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_result", bus.result, 16'h0);
    chk("rst_flag", bus.flag, 3'b000);
    chk("rst_busy", bus.busy, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    @(negedge clk) rst = 1'b0;

    run_op(4'd0, 16'h7FFF, 16'h0001, 4'd0, 0);
    chk("add_ovf_res", bus.result, 16'h8000);
    chk("add_ovf_flag", bus.flag, 3'b010);
    run_op(4'd1, 16'h0005, 16'h0005, 4'd0, 0);
    chk("sub_zero_flag", bus.flag, 3'b100);
    run_op(4'd4, 16'h0003, 16'h1234, 4'd4, 0);
    chk("sll_res", bus.result, 16'h0030);
    chk("sll_flag_kept", bus.flag, 3'b100);
    run_op(4'd7, 16'h8001, 16'h0000, 4'd1, 3);
    chk("rl_res", bus.result, 16'h0003);
    run_op(4'd7, 16'hA5C3, 16'h0000, 4'd0, 0);
    chk("rl_zero", bus.result, 16'hA5C3);
    run_op(4'd6, 16'hF000, 16'h0000, 4'd4, 0);
    chk("sra_res", bus.result, 16'hFF00);
    run_op(4'd5, 16'hF000, 16'h0000, 4'd4, 0);
    chk("srl_res", bus.result, 16'h0F00);
    run_op(4'd0, 16'h8000, 16'h8000, 4'd0, 0);
    run_op(4'd13, 16'h1111, 16'h2222, 4'd3, 1);
    chk("reserved_res", bus.result, 16'h0);
    run_op(4'd8, 16'h0003, 16'h0005, 4'd0, 0);
`ifdef ALU_MUL_EN
    chk("mul_res", bus.result, 16'h000F);
    run_op(4'd8, 16'h0100, 16'h0100, 4'd0, 1);
    chk("mul_hi_flag", bus.flag[2:1], 2'b11);
    run_op(4'd8, 16'hFFFF, 16'hFFFF, 4'd0, 0);

    // Reset in the fifth EXEC cycle discards the partial product.
    @(negedge clk);
    bus.op = 4'd8; bus.data1 = 16'h0003; bus.data2 = 16'h0007;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("mid_exec_busy", bus.busy, 1);
`else
    chk("reserved8_res", bus.result, 16'h0);
    @(negedge clk);
    bus.op = 4'd0; bus.data1 = 16'h0010; bus.data2 = 16'h0020;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    chk("pre_rst_valid", bus.out_valid, 1);
`endif
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("rst2_out_valid", bus.out_valid, 0);
    chk("rst2_flag", bus.flag, 3'b000);
    chk("rst2_result", bus.result, 16'h0);
    chk("rst2_in_ready", bus.in_ready, 1);
    chk("rst2_busy", bus.busy, 0);
    exp_flag = 3'b000;
    @(negedge clk) rst = 1'b0;
    run_op(4'd0, 16'h0001, 16'h0002, 4'd0, 0);
    chk("add_after_rst", bus.result, 16'h0003);

    for (int n = 0; n < 60; n++)
      run_op(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
             4'($urandom), $urandom_range(0, 2));

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
